// File: rtl/d_ptr_unit_if.sv
// Command and data-memory bus bundle for d_ptr_unit.
// The master modport is the pointer unit's view; slave is the environment's view.
interface d_ptr_unit_if #(
  parameter int unsigned d_addr_width = 8
);
  logic                    cmd_valid;
  logic [2:0]              cmd_op;
  logic [7:0]              cmd_wdata;
  logic                    cmd_ready;
  logic                    done;
  logic [d_addr_width-1:0] ptr;
  logic [7:0]              cell_data;
  logic                    cell_zero;
  logic                    err;
  logic                    d_req;
  logic                    d_dir;
  logic [d_addr_width-1:0] d_addr;
  logic [7:0]              d_wdata;
  logic                    d_ack;
  logic [7:0]              d_rdata;

  modport master (
    input  cmd_valid, cmd_op, cmd_wdata, d_ack, d_rdata,
    output cmd_ready, done, ptr, cell_data, cell_zero, err,
           d_req, d_dir, d_addr, d_wdata
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_wdata, d_ack, d_rdata,
    input  cmd_ready, done, ptr, cell_data, cell_zero, err,
           d_req, d_dir, d_addr, d_wdata
  );
endinterface

// File: rtl/d_ptr_unit.sv
// Data-pointer / cell unit: pointer moves, cell load/store and read-modify-write inc/dec.
// Define D_PTR_BOUNDS_EN to clamp the pointer to [0, d_mem_length-1] and flag a sticky err.
module d_ptr_unit #(
  parameter int unsigned d_addr_width = 8,
  parameter int unsigned d_mem_length = 64
) (
  input logic          clk,
  input logic          rst,
  d_ptr_unit_if.master bus
);

  if (d_mem_length == 0 || d_mem_length > (1 << d_addr_width)) begin : g_bad_len
    $error("d_mem_length must be in 1 .. 2**d_addr_width");
  end

  typedef enum logic [2:0] {StIdle, StRdReq, StRdGap, StWrReq, StDone} state_e;

  localparam logic [2:0] OpPtrInc    = 3'd0;
  localparam logic [2:0] OpPtrDec    = 3'd1;
  localparam logic [2:0] OpCellInc   = 3'd2;
  localparam logic [2:0] OpCellDec   = 3'd3;
  localparam logic [2:0] OpCellLoad  = 3'd4;
  localparam logic [2:0] OpCellStore = 3'd5;

  state_e                  state_q, state_d;
  logic [2:0]              op_q, op_d;
  logic [d_addr_width-1:0] ptr_q, ptr_d;
  logic [7:0]              cell_q, cell_d;
  logic [7:0]              wdata_q, wdata_d;
  logic                    err_q, err_d;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ptr_d   = ptr_q;
    cell_d  = cell_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          op_d = bus.cmd_op;
          case (bus.cmd_op)
            OpPtrInc: begin
`ifdef D_PTR_BOUNDS_EN
              if (ptr_q == d_addr_width'(d_mem_length - 1)) err_d = 1'b1;
              else                                           ptr_d = ptr_q + 1'b1;
`else
              ptr_d = ptr_q + 1'b1;
`endif
              state_d = StDone;
            end
            OpPtrDec: begin
`ifdef D_PTR_BOUNDS_EN
              if (ptr_q == '0) err_d = 1'b1;
              else             ptr_d = ptr_q - 1'b1;
`else
              ptr_d = ptr_q - 1'b1;
`endif
              state_d = StDone;
            end
            OpCellInc, OpCellDec, OpCellLoad: state_d = StRdReq;
            OpCellStore: begin
              wdata_d = bus.cmd_wdata;
              state_d = StWrReq;
            end
            default: state_d = StDone;
          endcase
        end
      end
      StRdReq: begin
        if (bus.d_ack) begin
          if (op_q == OpCellLoad) begin
            cell_d  = bus.d_rdata;
            state_d = StDone;
          end else begin
            // Read half of inc/dec: stage the modified value for the write-back.
            wdata_d = (op_q == OpCellInc) ? bus.d_rdata + 8'd1 : bus.d_rdata - 8'd1;
            state_d = StRdGap;
          end
        end
      end
      StRdGap: state_d = StWrReq;
      StWrReq: begin
        if (bus.d_ack) begin
          cell_d  = wdata_q;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= '0;
      ptr_q   <= '0;
      cell_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ptr_q   <= ptr_d;
      cell_q  <= cell_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.cmd_ready = (state_q == StIdle);
  assign bus.done      = (state_q == StDone);
  assign bus.d_req     = (state_q == StRdReq) || (state_q == StWrReq);
  assign bus.d_dir     = (state_q == StWrReq);
  assign bus.d_addr    = ptr_q;
  assign bus.d_wdata   = wdata_q;
  assign bus.ptr       = ptr_q;
  assign bus.cell_data = cell_q;
  assign bus.cell_zero = (cell_q == 8'd0);
`ifdef D_PTR_BOUNDS_EN
  assign bus.err       = err_q;
`else
  assign bus.err       = 1'b0;
`endif

endmodule
